// File: rtl/mmio_responder_if.sv
// CPU data-memory port and host output-stream signals for the MMIO responder.
// The slave modport is the responder; the master modport is the CPU/host side.
interface mmio_responder_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        io_hit;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        fifo_full;

  modport slave (
    input  mem_cmd, mem_addr, write_data, out_ready,
    output read_data, io_hit, out_data, out_valid, fifo_full
  );

  modport master (
    output mem_cmd, mem_addr, write_data, out_ready,
    input  read_data, io_hit, out_data, out_valid, fifo_full
  );
endinterface

// File: rtl/mmio_responder.sv
// I/O responder for CPU addresses 0x100-0x1FF: LED register, synchronized switches,
// free-running cycle counter and an output FIFO drained by a valid/ready host.
module mmio_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  mmio_responder_if.slave    bus,
  input  logic [7:0]         sw_in,
  output logic [7:0]         led_out
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [7:0] OFS_LED  = 8'h00;
  localparam logic [7:0] OFS_SW   = 8'h40;
  localparam logic [7:0] OFS_CNT  = 8'h80;
  localparam logic [7:0] OFS_FIFO = 8'hC0;
  localparam logic [7:0] OFS_STAT = 8'hC1;

  logic [7:0]       led_q, led_d;
  logic [7:0]       sw_meta_q, sw_sync_q;
  logic [15:0]      read_data_q, read_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic       io_hit, io_rd, io_wr;
  logic [7:0] ofs;
  logic       fifo_full, fifo_valid;
  logic       push_req, push_ok, pop;
  logic [15:0] rd_val;

  assign ofs    = bus.mem_addr[7:0];
  assign io_hit = bus.mem_addr[8] &&
                  (bus.mem_cmd == CMD_READ || bus.mem_cmd == CMD_WRITE);
  assign io_rd  = io_hit && (bus.mem_cmd == CMD_READ);
  assign io_wr  = io_hit && (bus.mem_cmd == CMD_WRITE);

  assign fifo_valid = (count_q != '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign pop        = fifo_valid && bus.out_ready;
  assign push_req   = io_wr && (ofs == OFS_FIFO);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_comb begin
    rd_val = 16'h0000;
    case (ofs)
      OFS_LED:  rd_val = {8'h00, led_q};
      OFS_SW:   rd_val = {8'h00, sw_sync_q};
      OFS_CNT:  rd_val = 16'(cnt_q);
      OFS_STAT: rd_val = {14'b0, fifo_full, ~fifo_valid};
      default:  rd_val = 16'h0000;
    endcase
  end

  always_comb begin
    led_d       = led_q;
    read_data_d = read_data_q;
    cnt_d       = cnt_q + CNT_W'(1);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (io_wr && ofs == OFS_LED) led_d = bus.write_data[7:0];
    if (io_wr && ofs == OFS_CNT) cnt_d = '0;
    if (io_rd)                   read_data_d = rd_val;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + (PTR_W + 1)'(1);
    else if (pop && !push_ok) count_d = count_q - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      read_data_q <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      led_q       <= led_d;
      sw_meta_q   <= sw_in;
      sw_sync_q   <= sw_meta_q;
      read_data_q <= read_data_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: out_data is gated to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.write_data;
  end

  assign led_out       = led_q;
  assign bus.read_data = read_data_q;
  assign bus.io_hit    = io_hit;
  assign bus.out_valid = fifo_valid;
  assign bus.fifo_full = fifo_full;
  assign bus.out_data  = fifo_valid ? mem_q[rd_ptr_q] : 16'h0000;
endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: a vector table for single-cycle accesses plus
// hand-written sequences for synchronizer, counter wrap, FIFO and reset corner cases.
module tb_mmio_responder;
  localparam logic [1:0] C_NONE = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_RSV = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw_in = 8'h00;
  logic [7:0] led_out;
  int checks = 0;
  int failures = 0;

  mmio_responder_if bus ();

  mmio_responder #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .sw_in  (sw_in),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic        hit;
    logic [15:0] rd;
    logic [7:0]  led;
    logic        valid;
    logic        full;
    logic [15:0] odata;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic [1:0] c, logic [8:0] a, logic [15:0] d, logic h,
                              logic [15:0] r, logic [7:0] l, logic v, logic f,
                              logic [15:0] o);
    vec_t t;
    t.cmd = c; t.addr = a; t.wdata = d; t.hit = h; t.rd = r;
    t.led = l; t.valid = v; t.full = f; t.odata = o;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    bus.mem_cmd = c;
    bus.mem_addr = a;
    bus.write_data = d;
    @(posedge clk);
    #1;
    bus.mem_cmd = C_NONE;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_cmd = C_NONE;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    cyc(C_WR, 9'h1C0, d);
  endtask

  initial begin
    bus.mem_cmd = C_NONE;
    bus.mem_addr = '0;
    bus.write_data = '0;
    bus.out_ready = 1'b0;

    // reset state
    #1;
    chk("rst read_data", bus.read_data, 16'h0000);
    chk("rst led", {8'h00, led_out}, 16'h0000);
    chk("rst out_valid", {15'b0, bus.out_valid}, 16'h0000);
    chk("rst fifo_full", {15'b0, bus.fifo_full}, 16'h0000);
    chk("rst out_data", bus.out_data, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    //               cmd    addr    wdata    hit rd       led    v     f     odata
    vecs[0]  = mk(C_WR,  9'h100, 16'h00A5, 1, 16'h0000, 8'hA5, 1'b0, 1'b0, 16'h0000);
    vecs[1]  = mk(C_RD,  9'h100, 16'h0000, 1, 16'h00A5, 8'hA5, 1'b0, 1'b0, 16'h0000);
    vecs[2]  = mk(C_WR,  9'h140, 16'hFFFF, 1, 16'h00A5, 8'hA5, 1'b0, 1'b0, 16'h0000);
    vecs[3]  = mk(C_RD,  9'h1C1, 16'h0000, 1, 16'h0001, 8'hA5, 1'b0, 1'b0, 16'h0000);
    vecs[4]  = mk(C_RD,  9'h1FF, 16'h0000, 1, 16'h0000, 8'hA5, 1'b0, 1'b0, 16'h0000);
    vecs[5]  = mk(C_RSV, 9'h100, 16'h005A, 0, 16'h0000, 8'hA5, 1'b0, 1'b0, 16'h0000);
    vecs[6]  = mk(C_WR,  9'h025, 16'h0077, 0, 16'h0000, 8'hA5, 1'b0, 1'b0, 16'h0000);
    vecs[7]  = mk(C_RD,  9'h100, 16'h0000, 1, 16'h00A5, 8'hA5, 1'b0, 1'b0, 16'h0000);
    vecs[8]  = mk(C_RD,  9'h000, 16'h0000, 0, 16'h00A5, 8'hA5, 1'b0, 1'b0, 16'h0000);
    vecs[9]  = mk(C_RSV, 9'h1C0, 16'hBEEF, 0, 16'h00A5, 8'hA5, 1'b0, 1'b0, 16'h0000);
    vecs[10] = mk(C_WR,  9'h1C0, 16'h1234, 1, 16'h00A5, 8'hA5, 1'b1, 1'b0, 16'h1234);
    vecs[11] = mk(C_RD,  9'h1C0, 16'h0000, 1, 16'h0000, 8'hA5, 1'b1, 1'b0, 16'h1234);
    vecs[12] = mk(C_RD,  9'h1C1, 16'h0000, 1, 16'h0000, 8'hA5, 1'b1, 1'b0, 16'h1234);
    vecs[13] = mk(C_WR,  9'h101, 16'h00FF, 1, 16'h0000, 8'hA5, 1'b1, 1'b0, 16'h1234);
    vecs[14] = mk(C_RD,  9'h100, 16'h0000, 1, 16'h00A5, 8'hA5, 1'b1, 1'b0, 16'h1234);

    for (int i = 0; i < 15; i++) begin
      bus.mem_cmd = vecs[i].cmd;
      bus.mem_addr = vecs[i].addr;
      bus.write_data = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d io_hit", i), {15'b0, bus.io_hit}, {15'b0, vecs[i].hit});
      @(posedge clk);
      #1;
      bus.mem_cmd = C_NONE;
      chk($sformatf("vec%0d read_data", i), bus.read_data, vecs[i].rd);
      chk($sformatf("vec%0d led", i), {8'h00, led_out}, {8'h00, vecs[i].led});
      chk($sformatf("vec%0d out_valid", i), {15'b0, bus.out_valid}, {15'b0, vecs[i].valid});
      chk($sformatf("vec%0d fifo_full", i), {15'b0, bus.fifo_full}, {15'b0, vecs[i].full});
      chk($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].odata);
    end

    // switch synchronizer latency
    do_reset();
    sw_in = 8'h3C;
    cyc(C_NONE, 9'h000, 16'h0000);
    cyc(C_NONE, 9'h000, 16'h0000);
    sw_in = 8'hC3;
    cyc(C_RD, 9'h140, 16'h0000);
    chk("sw first read", bus.read_data, 16'h003C);
    cyc(C_RD, 9'h140, 16'h0000);
    chk("sw one later", bus.read_data, 16'h003C);
    cyc(C_RD, 9'h140, 16'h0000);
    chk("sw two later", bus.read_data, 16'h00C3);

    // counter clear, count, wrap
    do_reset();
    cyc(C_WR, 9'h180, 16'h1234);
    cyc(C_RD, 9'h180, 16'h0000);
    chk("cnt after clear", bus.read_data, 16'h0000);
    cyc(C_WR, 9'h180, 16'h0000);
    for (int i = 0; i < 10; i++) cyc(C_NONE, 9'h000, 16'h0000);
    cyc(C_RD, 9'h180, 16'h0000);
    chk("cnt 10 idle", bus.read_data, 16'h000A);
    cyc(C_WR, 9'h180, 16'h0000);
    for (int i = 0; i < 65535; i++) cyc(C_NONE, 9'h000, 16'h0000);
    cyc(C_RD, 9'h180, 16'h0000);
    chk("cnt max", bus.read_data, 16'hFFFF);
    cyc(C_RD, 9'h180, 16'h0000);
    chk("cnt wrap", bus.read_data, 16'h0000);

    // fill, overflow drop, drain
    do_reset();
    push(16'd1); push(16'd2); push(16'd3);
    chk("fill3 full", {15'b0, bus.fifo_full}, 16'h0000);
    push(16'd4);
    chk("fill4 full", {15'b0, bus.fifo_full}, 16'h0001);
    push(16'd5);
    chk("overflow full", {15'b0, bus.fifo_full}, 16'h0001);
    cyc(C_RD, 9'h1C1, 16'h0000);
    chk("stat full", bus.read_data, 16'h0002);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d data", k), bus.out_data, 16'(k));
      chk($sformatf("drain%0d valid", k), {15'b0, bus.out_valid}, 16'h0001);
      cyc(C_NONE, 9'h000, 16'h0000);
    end
    chk("drained valid", {15'b0, bus.out_valid}, 16'h0000);
    chk("drained data", bus.out_data, 16'h0000);
    cyc(C_RD, 9'h1C1, 16'h0000);
    chk("stat empty", bus.read_data, 16'h0001);
    bus.out_ready = 1'b0;

    // push and pop together while full
    do_reset();
    push(16'd1); push(16'd2); push(16'd3); push(16'd4);
    bus.out_ready = 1'b1;
    push(16'd9);
    chk("full pushpop full", {15'b0, bus.fifo_full}, 16'h0001);
    begin
      logic [15:0] exp_q[4];
      exp_q[0] = 16'd2; exp_q[1] = 16'd3; exp_q[2] = 16'd4; exp_q[3] = 16'd9;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("pp drain%0d", k), bus.out_data, exp_q[k]);
        cyc(C_NONE, 9'h000, 16'h0000);
      end
    end
    chk("pp empty", {15'b0, bus.out_valid}, 16'h0000);

    // push and pop together with one entry: count unchanged
    bus.out_ready = 1'b0;
    push(16'd5);
    bus.out_ready = 1'b1;
    push(16'd6);
    chk("one pushpop valid", {15'b0, bus.out_valid}, 16'h0001);
    chk("one pushpop data", bus.out_data, 16'd6);
    cyc(C_NONE, 9'h000, 16'h0000);
    chk("one pushpop drained", {15'b0, bus.out_valid}, 16'h0000);

    // reset in the middle of a drain
    do_reset();
    push(16'd7); push(16'd8);
    cyc(C_WR, 9'h100, 16'h0033);
    cyc(C_RD, 9'h100, 16'h0000);
    chk("pre-reset read", bus.read_data, 16'h0033);
    bus.out_ready = 1'b1;
    cyc(C_NONE, 9'h000, 16'h0000);
    chk("mid-drain data", bus.out_data, 16'd8);
    #2;
    reset = 1'b1;
    #1;
    chk("async rst valid", {15'b0, bus.out_valid}, 16'h0000);
    chk("async rst led", {8'h00, led_out}, 16'h0000);
    chk("async rst read_data", bus.read_data, 16'h0000);
    chk("async rst out_data", bus.out_data, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b0;
    cyc(C_RD, 9'h180, 16'h0000);
    chk("post-rst cnt", bus.read_data, 16'h0000);
    bus.mem_cmd = C_WR;
    bus.mem_addr = 9'h025;
    bus.write_data = 16'h00FF;
    #1;
    chk("ram io_hit", {15'b0, bus.io_hit}, 16'h0000);
    @(posedge clk);
    #1;
    bus.mem_cmd = C_NONE;
    chk("ram led", {8'h00, led_out}, 16'h0000);
    chk("ram valid", {15'b0, bus.out_valid}, 16'h0000);
    chk("ram read_data", bus.read_data, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
